// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache: default geometry, address
// split helpers and the refill FSM state encoding.
// Optional build macro used by instr_cache: ICACHE_STATS_EN (hit/miss counters).
package instr_cache_pkg;

  localparam int unsigned SETS_DEF       = 16;
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned ADDR_W         = 32;
  localparam int unsigned BYTE_OFF_W     = 2;

  // Refill FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_REFILL    = 2'd1;
  localparam state_t ST_FILL_DONE = 2'd2;

  // Bits left for the tag once byte offset, word offset and index are removed
  function automatic int unsigned tag_width(input int unsigned sets,
                                            input int unsigned line_words);
    return ADDR_W - BYTE_OFF_W - $clog2(line_words) - $clog2(sets);
  endfunction

endpackage

// File: rtl/instr_cache_array.sv
// icache_array: data and tag storage for the direct-mapped instruction cache.
// Reads are combinational, writes are synchronous. Valid bits live in the
// cache controller so that reset can clear them asynchronously.
// Ports:
//   clk_i                          write clock
//   rd_idx_i / rd_off_i            fetch read index / word offset
//   rd_data_o / rd_tag_o           word and tag at the fetch index
//   inv_idx_i / inv_tag_o          second tag read port for store snoops
//   wr_en_i, wr_idx_i, wr_off_i,
//   wr_data_i                      refill word write
//   tag_we_i, tag_i                tag write (at wr_idx_i)
module icache_array
  import instr_cache_pkg::*;
#(
  parameter int unsigned SETS       = SETS_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned TAG_W      = tag_width(SETS_DEF, LINE_WORDS_DEF)
) (
  input  logic                          clk_i,
  input  logic [$clog2(SETS)-1:0]       rd_idx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_off_i,
  output logic [31:0]                   rd_data_o,
  output logic [TAG_W-1:0]              rd_tag_o,
  input  logic [$clog2(SETS)-1:0]       inv_idx_i,
  output logic [TAG_W-1:0]              inv_tag_o,
  input  logic                          wr_en_i,
  input  logic [$clog2(SETS)-1:0]       wr_idx_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_off_i,
  input  logic [31:0]                   wr_data_i,
  input  logic                          tag_we_i,
  input  logic [TAG_W-1:0]              tag_i
);

  logic [31:0]      data_q [SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];

  assign rd_data_o = data_q[{rd_idx_i, rd_off_i}];
  assign rd_tag_o  = tag_q[rd_idx_i];
  assign inv_tag_o = tag_q[inv_idx_i];

  // Refill word write
  always_ff @(posedge clk_i) begin
    if (wr_en_i) data_q[{wr_idx_i, wr_off_i}] <= wr_data_i;
  end

  // Tag write on the final refill beat
  always_ff @(posedge clk_i) begin
    if (tag_we_i) tag_q[wr_idx_i] <= tag_i;
  end

endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache with a zero-latency hit path,
// line refill from main memory and store-snoop invalidation.
// Build macro: ICACHE_STATS_EN adds saturating hitCnt_o / missCnt_o.
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   addr_i, validReq_i            fetch request
//   instr_o, ready_o              fetch response (combinational on hit)
//   memReq_o, memAddr_o           refill request and line-aligned address
//   memData_i, memValid_i         refill beats
//   invEn_i, invAddr_i            store snoop invalidate
//   hitCnt_o, missCnt_o           statistics (ICACHE_STATS_EN only)
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned SETS       = SETS_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        validReq_i,
  output logic [31:0] instr_o,
  output logic        ready_o,
  output logic        memReq_o,
  output logic [31:0] memAddr_o,
  input  logic [31:0] memData_i,
  input  logic        memValid_i,
  input  logic        invEn_i,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hitCnt_o,
  output logic [31:0] missCnt_o,
`endif
  input  logic [31:0] invAddr_i
);

  localparam int unsigned OFF_W    = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W    = $clog2(SETS);
  localparam int unsigned TAG_W    = tag_width(SETS, LINE_WORDS);
  localparam int unsigned LINE_LSB = OFF_W + BYTE_OFF_W;

  state_t                     state_q, state_d;
  logic [SETS-1:0]            valid_q, valid_d;
  logic [OFF_W-1:0]           beat_q, beat_d;
  logic [ADDR_W-1:LINE_LSB]   line_q, line_d;   // {tag, index} of line under refill
  logic                       inv_pend_q, inv_pend_d;

  logic [OFF_W-1:0] req_off_s;
  logic [IDX_W-1:0] req_idx_s, inv_idx_s, fill_idx_s;
  logic [TAG_W-1:0] req_tag_s, inv_tag_s, rd_tag_s, inv_rd_tag_s;
  logic [31:0]      rd_data_s;
  logic             hit_s, miss_s, inv_hit_s, inv_fill_s, fill_we_s, beat_last_s;
  logic             unused_s;

  assign req_off_s  = addr_i[LINE_LSB-1:BYTE_OFF_W];
  assign req_idx_s  = addr_i[LINE_LSB+IDX_W-1:LINE_LSB];
  assign req_tag_s  = addr_i[ADDR_W-1:LINE_LSB+IDX_W];
  assign inv_idx_s  = invAddr_i[LINE_LSB+IDX_W-1:LINE_LSB];
  assign inv_tag_s  = invAddr_i[ADDR_W-1:LINE_LSB+IDX_W];
  assign fill_idx_s = line_q[LINE_LSB+IDX_W-1:LINE_LSB];
  // Byte-offset bits never select anything
  assign unused_s   = ^{addr_i[BYTE_OFF_W-1:0], invAddr_i[BYTE_OFF_W-1:0]};

  icache_array #(
    .SETS      (SETS),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAG_W)
  ) u_array (
    .clk_i    (clk_i),
    .rd_idx_i (req_idx_s),
    .rd_off_i (req_off_s),
    .rd_data_o(rd_data_s),
    .rd_tag_o (rd_tag_s),
    .inv_idx_i(inv_idx_s),
    .inv_tag_o(inv_rd_tag_s),
    .wr_en_i  (fill_we_s),
    .wr_idx_i (fill_idx_s),
    .wr_off_i (beat_q),
    .wr_data_i(memData_i),
    .tag_we_i (beat_last_s),
    .tag_i    (line_q[ADDR_W-1:LINE_LSB+IDX_W])
  );

  assign hit_s       = (state_q == ST_IDLE) && validReq_i && valid_q[req_idx_s] &&
                       (rd_tag_s == req_tag_s);
  assign miss_s      = (state_q == ST_IDLE) && validReq_i && !hit_s;
  assign fill_we_s   = (state_q == ST_REFILL) && memValid_i;
  assign beat_last_s = fill_we_s && (beat_q == OFF_W'(LINE_WORDS - 1));
  assign inv_hit_s   = invEn_i && valid_q[inv_idx_s] && (inv_rd_tag_s == inv_tag_s);
  // Snoop against the in-flight line: its valid bit is not yet set
  assign inv_fill_s  = invEn_i && (state_q == ST_REFILL) &&
                       (invAddr_i[ADDR_W-1:LINE_LSB] == line_q);

  assign ready_o   = hit_s;
  assign instr_o   = hit_s ? rd_data_s : 32'h0000_0000;
  assign memReq_o  = (state_q == ST_REFILL);
  assign memAddr_o = {line_q, {LINE_LSB{1'b0}}};

  // Refill FSM next-state, beat counter and line latch
  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    line_d     = line_q;
    inv_pend_d = inv_pend_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_s) begin
          state_d    = ST_REFILL;
          line_d     = addr_i[ADDR_W-1:LINE_LSB];
          beat_d     = {OFF_W{1'b0}};
          inv_pend_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REFILL: begin
        if (fill_we_s) begin
          beat_d = beat_q + {{(OFF_W-1){1'b0}}, 1'b1};  // wraps to 0 after last beat
        end else begin
          beat_d = beat_q;
        end
        if (beat_last_s) begin
          state_d = ST_FILL_DONE;
        end else begin
          state_d = ST_REFILL;
        end
        if (inv_fill_s) begin
          inv_pend_d = 1'b1;
        end else begin
          inv_pend_d = inv_pend_q;
        end
      end
      ST_FILL_DONE: state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Valid-bit updates: snoop clear, drop the victim on refill start, set on fill
  always_comb begin
    valid_d = valid_q;
    if (inv_hit_s) begin
      valid_d[inv_idx_s] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    // Victim data is overwritten during refill, so it must stop hitting now
    if (miss_s) begin
      valid_d[req_idx_s] = 1'b0;
    end else begin
      valid_d = valid_d;
    end
    if (beat_last_s && !inv_pend_q && !inv_fill_s) begin
      valid_d[fill_idx_s] = 1'b1;
    end else begin
      valid_d = valid_d;
    end
  end

  // Controller state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      valid_q    <= {SETS{1'b0}};
      beat_q     <= {OFF_W{1'b0}};
      line_q     <= {(ADDR_W-LINE_LSB){1'b0}};
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      inv_pend_q <= inv_pend_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit and refill-entry counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= 32'h0000_0000;
      miss_cnt_q <= 32'h0000_0000;
    end else begin
      if (hit_s && (hit_cnt_q != 32'hFFFF_FFFF)) hit_cnt_q <= hit_cnt_q + 32'h0000_0001;
      if (miss_s && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'h0000_0001;
    end
  end

  assign hitCnt_o  = hit_cnt_q;
  assign missCnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instr_cache.sv
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        validReq;
  logic [31:0] instr;
  logic        ready;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memValid;
  logic        invEn;
  logic [31:0] invAddr;
`ifdef ICACHE_STATS_EN
  logic [31:0] hitCnt, missCnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: 16 sets x 4 words, tag = addr[31:8]
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];

  always #5 clk = ~clk;

  instr_cache dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .addr_i    (addr),
    .validReq_i(validReq),
    .instr_o   (instr),
    .ready_o   (ready),
    .memReq_o  (memReq),
    .memAddr_o (memAddr),
    .memData_i (memData),
    .memValid_i(memValid),
    .invEn_i   (invEn),
`ifdef ICACHE_STATS_EN
    .hitCnt_o  (hitCnt),
    .missCnt_o (missCnt),
`endif
    .invAddr_i (invAddr)
  );

  // Main-memory contents; line 0x10 holds 0xA0..0xA3
  function automatic logic [31:0] memw(input logic [31:0] a);
    if (a[31:4] == 28'h000_0001) return 32'h0000_00A0 + {30'b0, a[3:2]};
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[7:4]] && (m_tag[a[7:4]] == a[31:8]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_inv(input logic [31:0] a);
    if (m_hit(a)) m_valid[a[7:4]] = 1'b0;
  endtask

  task automatic m_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch: hit checked same cycle; miss is refilled with fixed timing
  // (1 miss cycle + 4 beats + 1 done cycle, then the request must hit).
  task automatic fetch(input logic [31:0] a, input bit gaps, input int inv_beat,
                       input logic [31:0] inv_a);
    logic [31:0] line;
    int          s;
    bit          exp_hit;
    bit          suppress;
    line     = {a[31:4], 4'h0};
    s        = int'(a[7:4]);
    suppress = 1'b0;
    @(posedge clk); #1;
    addr = a; validReq = 1'b1; invEn = 1'b0;
    @(negedge clk);
    exp_hit = m_hit(a);
    chk("fetch_ready", {31'b0, ready}, {31'b0, exp_hit});
    if (exp_hit) begin
      chk("hit_instr", instr, m_data[s][a[3:2]]);
      chk("hit_memreq", {31'b0, memReq}, 32'h0);
      @(posedge clk); #1;
      validReq = 1'b0;
      return;
    end
    @(posedge clk); #1;
    m_valid[s] = 1'b0;
    // Fetch-side changes during the refill must be ignored
    addr = $urandom; validReq = 1'($urandom_range(0, 1));
    chk("refill_addr", memAddr, line);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          memValid = 1'b0;
          @(negedge clk);
          chk("gap_req", {31'b0, memReq}, 32'h1);
          @(posedge clk); #1;
        end
      end
      memValid = 1'b1;
      memData  = memw(line + 32'(4 * k));
      if (k == inv_beat) begin invEn = 1'b1; invAddr = inv_a; end
      @(negedge clk);
      chk("refill_req", {31'b0, memReq}, 32'h1);
      chk("refill_ready", {31'b0, ready}, 32'h0);
      chk("refill_addr_stable", memAddr, line);
      @(posedge clk); #1;
      memValid    = 1'b0;
      m_data[s][k] = memw(line + 32'(4 * k));
      if (k == inv_beat) begin
        invEn = 1'b0;
        if (inv_a[31:4] == line[31:4]) suppress = 1'b1;
        else m_inv(inv_a);
      end
    end
    chk("done_req", {31'b0, memReq}, 32'h0);
    chk("done_ready", {31'b0, ready}, 32'h0);
    addr = a; validReq = 1'b1;
    @(posedge clk); #1;
    if (!suppress) begin m_valid[s] = 1'b1; m_tag[s] = a[31:8]; end
    chk("post_fill_ready", {31'b0, ready}, {31'b0, !suppress});
    if (!suppress) begin
      chk("post_fill_instr", instr, m_data[s][a[3:2]]);
      @(posedge clk); #1;
    end
    validReq = 1'b0;
  endtask

  task automatic snoop(input logic [31:0] a);
    @(posedge clk); #1;
    validReq = 1'b0; invEn = 1'b1; invAddr = a;
    @(posedge clk); #1;
    invEn = 1'b0;
    m_inv(a);
  endtask

  function automatic logic [31:0] pool_addr();
    logic [31:0] a;
    a      = 32'h0;
    a[9:8] = 2'($urandom_range(0, 3));
    a[5:4] = 2'($urandom_range(0, 3));
    a[3:2] = 2'($urandom_range(0, 3));
    a[1:0] = 2'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    rst_n = 1'b0; addr = 32'h0; validReq = 1'b0; memData = 32'h0;
    memValid = 1'b0; invEn = 1'b0; invAddr = 32'h0;
    m_clear();
    #12;
    chk("rst_memreq", {31'b0, memReq}, 32'h0);
    chk("rst_memaddr", memAddr, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_instr", instr, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("rst_hitcnt", hitCnt, 32'h0);
    chk("rst_misscnt", missCnt, 32'h0);
`endif
    @(negedge clk); rst_n = 1'b1;

    // Cold miss on 0x10, then same-line hit on 0x1C
    fetch(32'h0000_0010, 1'b0, -1, 32'h0);
    chk("cold_word0", m_data[1][0], 32'h0000_00A0);
    fetch(32'h0000_001C, 1'b0, -1, 32'h0);
`ifdef ICACHE_STATS_EN
    chk("stat_hits", hitCnt, 32'd2);
    chk("stat_misses", missCnt, 32'd1);
`endif

    // Conflict on set 1 evicts 0x10
    fetch(32'h0000_0110, 1'b0, -1, 32'h0);
    fetch(32'h0000_0010, 1'b0, -1, 32'h0);

    // Snoop hits the line under refill: fill completes but stays invalid
    fetch(32'h0000_0110, 1'b0, 1, 32'h0000_0114);
    fetch(32'h0000_0110, 1'b0, -1, 32'h0);

    // Hit and snoop to the same line in one cycle
    @(posedge clk); #1;
    addr = 32'h0000_0118; validReq = 1'b1; invEn = 1'b1; invAddr = 32'h0000_0110;
    @(negedge clk);
    chk("hit_inv_ready", {31'b0, ready}, 32'h1);
    chk("hit_inv_instr", instr, m_data[1][2]);
    @(posedge clk); #1;
    invEn = 1'b0; validReq = 1'b0;
    m_inv(32'h0000_0110);
    fetch(32'h0000_0118, 1'b0, -1, 32'h0);

    // Reset after the second refill beat
    @(posedge clk); #1;
    addr = 32'h0000_0210; validReq = 1'b1;
    @(posedge clk); #1;
    validReq = 1'b0;
    for (int k = 0; k < 2; k++) begin
      memValid = 1'b1; memData = memw(32'h0000_0210 + 32'(4 * k));
      @(posedge clk); #1;
    end
    memValid = 1'b0;
    chk("pre_rst_req", {31'b0, memReq}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_memreq", {31'b0, memReq}, 32'h0);
    chk("abort_memaddr", memAddr, 32'h0);
    chk("abort_ready", {31'b0, ready}, 32'h0);
    m_clear();
    @(negedge clk); rst_n = 1'b1;
    fetch(32'h0000_0010, 1'b0, -1, 32'h0);
    fetch(32'h0000_0118, 1'b0, -1, 32'h0);

    // Randomized traffic over a small address pool
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      a = pool_addr();
      if (r < 2) snoop(pool_addr());
      else if (r >= 8) fetch(a, 1'b1, $urandom_range(0, 3), (r == 9) ? a : pool_addr());
      else fetch(a, 1'b1, -1, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
